// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// PC-source and write-back-source codes, plus opcode classification helpers.
package kgp_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned WB_SEL_W = 2;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ALU_REG = 6'b000000;
  localparam opcode_t OP_ALU_IMM = 6'b000001;
  localparam opcode_t OP_LW      = 6'b000010;
  localparam opcode_t OP_SW      = 6'b000011;
  localparam opcode_t OP_BLTZ    = 6'b000111;
  localparam opcode_t OP_BZ      = 6'b001000;
  localparam opcode_t OP_BNZ     = 6'b001001;
  localparam opcode_t OP_BR      = 6'b001010;
  localparam opcode_t OP_B       = 6'b001011;
  localparam opcode_t OP_BL      = 6'b001100;
  localparam opcode_t OP_BCY     = 6'b001101;
  localparam opcode_t OP_BNCY    = 6'b001110;
  localparam opcode_t OP_HALT    = 6'b111111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [PC_SRC_W-1:0] PC_PLUS4  = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_REG    = 2'b10;

  localparam logic [WB_SEL_W-1:0] WB_ALU  = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_MEM  = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_LINK = 2'b10;

  function automatic logic is_alu(input opcode_t op);
    return (op == OP_ALU_REG) || (op == OP_ALU_IMM);
  endfunction

  function automatic logic is_mem(input opcode_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input opcode_t op);
    return op inside {OP_BLTZ, OP_BZ, OP_BNZ, OP_BR, OP_B, OP_BL, OP_BCY, OP_BNCY};
  endfunction

  function automatic logic is_defined(input opcode_t op);
    return is_alu(op) || is_mem(op) || is_branch(op) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/handshake bundle between the controller and the memory port.
interface multicycle_ctrl_if;

  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );

endinterface

// File: rtl/multicycle_ctrl_branch_eval.sv
// Combinational branch-taken decision from opcode, ALU flags and the carry flag.
module branch_eval
  import kgp_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            sign,
  input  logic            zero,
  input  logic            carry_q,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BLTZ:             taken = sign & ~zero;
      OP_BZ:               taken = ~sign & zero;
      OP_BNZ:              taken = ~zero;
      OP_BCY:              taken = carry_q;
      OP_BNCY:             taken = ~carry_q;
      OP_BR, OP_B, OP_BL:  taken = 1'b1;
      default:             taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT). Strobes are
// decoded from state, opcode and mem_ready; only state and carry_q are stored.
module multicycle_ctrl
  import kgp_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     opcode,
  input  logic                alu_sign,
  input  logic                alu_carry,
  input  logic                alu_zero,
  multicycle_ctrl_if.master   mem,
  output logic                ir_we,
  output logic                pc_we,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                reg_we,
  output logic [WB_SEL_W-1:0] wb_sel,
  output logic                alu_src_imm,
  output logic                carry_q,
  output logic                halted,
  output logic                ill_op
);

  state_t r_state;
  state_t w_next_state;
  logic   r_carry_q;
  logic   w_carry_we;
  logic   w_taken;

  branch_eval u_branch_eval (
    .opcode  (opcode),
    .sign    (alu_sign),
    .zero    (alu_zero),
    .carry_q (r_carry_q),
    .taken   (w_taken)
  );

  // Reset abandons any pending memory request; FETCH reissues it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_carry_q <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_carry_we) r_carry_q <= alu_carry;
    end
  end

  assign carry_q = r_carry_q;

  always_comb begin
    w_next_state     = r_state;
    w_carry_we       = 1'b0;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pc_src           = PC_PLUS4;
    reg_we           = 1'b0;
    wb_sel           = WB_ALU;
    alu_src_imm      = 1'b0;
    halted           = 1'b0;
    ill_op           = 1'b0;

    // Reset forces every decoded output low, whatever the current state.
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_we        = 1'b1;
            pc_we        = 1'b1;
            w_next_state = ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (opcode == OP_HALT) begin
            w_next_state = ST_HALT;
          end else if (!is_defined(opcode)) begin
            ill_op       = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (is_alu(opcode)) begin
            alu_src_imm  = (opcode == OP_ALU_IMM);
            w_carry_we   = 1'b1;
            w_next_state = ST_WB;
          end else if (is_mem(opcode)) begin
            alu_src_imm  = 1'b1;
            w_next_state = ST_MEM;
          end else begin
            w_next_state = ST_FETCH;
            if (w_taken) begin
              pc_we  = 1'b1;
              pc_src = (opcode == OP_BR) ? PC_REG : PC_BRANCH;
            end
            if (opcode == OP_BL) begin
              reg_we = 1'b1;
              wb_sel = WB_LINK;
            end
          end
        end

        ST_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (opcode == OP_SW);
          if (mem.mem_ready) begin
            w_next_state = (opcode == OP_LW) ? ST_WB : ST_FETCH;
          end
        end

        ST_WB: begin
          reg_we       = 1'b1;
          wb_sel       = (opcode == OP_LW) ? WB_MEM : WB_ALU;
          w_next_state = ST_FETCH;
        end

        ST_HALT: begin
          halted = 1'b1;
        end

        default: begin
          w_next_state = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  current IR opcode; valid from DECODE onward.
REQ-005 alu_sign, alu_carry, alu_zero  in  1 each  combinational ALU flags of the current EXEC operation.
REQ-006 mem_ready  in  1  memory completes the pending request in this cycle.
REQ-007 mem_req  out  1  memory request; held until mem_ready.
REQ-008 mem_we  out  1  store qualifier for mem_req.
REQ-009 mem_addr_sel  out  1  address source: 0 = PC, 1 = ALU result.
REQ-010 ir_we  out  1  IR load strobe.
REQ-011 pc_we  out  1  PC load strobe.
REQ-012 pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = register.
REQ-013 reg_we  out  1  register-file write strobe.
REQ-014 wb_sel  out  2  write-back source: 00 = ALU, 01 = memory data, 10 = link (PC).
REQ-015 alu_src_imm  out  1  ALU operand B comes from the immediate.
REQ-016 carry_q  out  1  architectural carry flag.
REQ-017 halted  out  1  high while in HALT.
REQ-018 ill_op  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-019 States SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT; outputs are decoded from state, opcode and mem_ready, and default to 0.
REQ-020 FETCH SHALL drive mem_req=1 and mem_addr_sel=0; on mem_ready it SHALL pulse ir_we=1 and pc_we=1 with pc_src=00, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-021 DECODE SHALL go to HALT for 111111, pulse ill_op and return to FETCH for undefined opcodes, and otherwise go to EXEC.
REQ-022 The defined opcodes SHALL be:
- 000000 ALU-reg
- 000001 ALU-imm
- 000010 lw
- 000011 sw
- 000111 bltz
- 001000 bz
- 001001 bnz
- 001010 br
- 001011 b
- 001100 bl
- 001101 bcy
- 001110 bncy
- 111111 halt
REQ-023 EXEC for ALU ops SHALL set alu_src_imm for 000001 and latch carry_q <= alu_carry, then go to WB.
REQ-024 WB SHALL pulse reg_we=1 with wb_sel=00 after an ALU op and wb_sel=01 after lw, then go to FETCH.
REQ-025 EXEC for lw/sw SHALL set alu_src_imm=1 and go to MEM.
REQ-026 MEM SHALL drive mem_req=1 and mem_addr_sel=1, plus mem_we=1 for sw, until mem_ready; then lw goes to WB and sw goes to FETCH.
REQ-027 EXEC for branches SHALL go to FETCH and assert pc_we only when the branch is taken.
REQ-028 Taken conditions SHALL be:
- bltz: sign & !zero
- bz: !sign & zero
- bnz: !zero
- bcy: carry_q
- bncy: !carry_q
- br, b, bl: always taken
REQ-029 Taken branches SHALL use pc_src=10 for br and pc_src=01 otherwise.
REQ-030 bl SHALL additionally pulse reg_we=1 with wb_sel=10 in the same EXEC cycle.
REQ-031 Branches and memory ops SHALL NOT modify carry_q.
REQ-032 HALT SHALL hold halted=1 with all other outputs 0 until rst.
REQ-033 Latency with mem_ready tied high SHALL be:
- ALU: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- branch: 3 cycles
- Each memory wait cycle adds exactly 1 cycle.
REQ-034 mem_req SHALL NOT deassert before mem_ready, and no strobe (ir_we, pc_we, reg_we) SHALL fire more than once per instruction.

Reset
REQ-035 When rst is sampled high, the next state SHALL be FETCH and carry_q SHALL be 0, regardless of the current state or a pending memory request.
REQ-036 While rst is high, every output except carry_q SHALL read 0.
REQ-037 In the first cycle after rst deasserts, mem_req SHALL be 1; an abandoned request SHALL be reissued from FETCH.

Structure
REQ-038 The opcode constants, state encoding, and pc_src/wb_sel codes SHALL live in the shared package kgp_ctrl_pkg.
REQ-039 Branch condition evaluation SHALL be the combinational sub-module branch_eval, with inputs opcode, sign, zero and carry_q and output taken.

Verification
REQ-040 Reset then ALU-reg (000000) with mem_ready=1 and alu_carry=1 -> ir_we at cycle 1, reg_we with wb_sel=00 at cycle 4, carry_q=1 afterwards.
REQ-041 lw with mem_ready low for 2 MEM cycles -> mem_req and mem_addr_sel held high for 3 cycles, then reg_we with wb_sel=01 exactly once.
REQ-042 bz with sign=0, zero=1 -> pc_we=1 and pc_src=01 in EXEC; the same instruction with zero=0 -> no pc_we, next state FETCH.
REQ-043 bl -> pc_we=1, pc_src=01, reg_we=1 and wb_sel=10 in the same cycle; br -> pc_src=10.
REQ-044 rst asserted during MEM of sw -> mem_req=0 and mem_we=0 next cycle, carry_q=0, FETCH restarts with mem_req=1.
REQ-045 Opcode 010101 -> single ill_op pulse, return to FETCH; opcode 111111 -> halted=1 held for 10 cycles until rst.
